// File: rtl/lsb_pkg.sv
// lsb_pkg: shared definitions for the load/store buffer.
//   - memory op encodings as carried by dispatch (disp_op)
//   - MEM_LEN_* access size codes driven on mem_len
//   - FSM state enum for the memory issue machine
//   - helpers: store detection, access length, load extension
package lsb_pkg;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_SB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_LHU = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SW  = 3'd7;

   localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
   localparam logic [1:0] MEM_LEN_HALF = 2'd1;
   localparam logic [1:0] MEM_LEN_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_STORE,
      ST_DRAIN
   } lsb_state_e;

   function automatic logic is_store(input logic [2:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   function automatic logic [1:0] op_len(input logic [2:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_len = MEM_LEN_BYTE;
         OP_LH, OP_LHU, OP_SH: op_len = MEM_LEN_HALF;
         default:              op_len = MEM_LEN_WORD;
      endcase
   endfunction

   // Sign/zero extension of an already right-aligned load value.
   function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] raw);
      case (op)
         OP_LB:   ext = {{24{raw[7]}}, raw[7:0]};
         OP_LH:   ext = {{16{raw[15]}}, raw[15:0]};
         OP_LBU:  ext = {24'h0, raw[7:0]};
         OP_LHU:  ext = {16'h0, raw[15:0]};
         default: ext = raw;
      endcase
   endfunction

endpackage

// File: rtl/lsb_load_ext.sv
// lsb_load_ext: combinational load data formatting.
//   op_i       in  3   load op of the access in flight
//   addr_lo_i  in  2   low address bits, select byte/half lane
//   rdata_i    in  32  raw word from the memory controller
//   data_o     out 32  selected and sign/zero-extended value
module lsb_load_ext
   import lsb_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);
   logic [31:0] lane;

   // Bring the addressed byte/half down to bit 0 before extension.
   assign lane   = rdata_i >> {addr_lo_i, 3'b000};
   assign data_o = ext(op_i, lane);

endmodule

// File: rtl/load_store_buffer.sv
// load_store_buffer: in-order load/store queue between dispatch/AGU and memory.
//   clk_in, rst_n_in (async, active low), rdy_in (global hold), clear_in (rob flush)
//   disp_*   : enqueue one memory op in program order; full is registered
//   agu_*    : address/store data for the entry with a matching tag
//   commit_* : rob commit of a store
//   mem_*    : single outstanding request, held until mem_done
//   ld_*     : one-cycle load result report to the rob
module load_store_buffer
   import lsb_pkg::*;
#(
   parameter int LSB_WIDTH = 3,
   parameter int LSB_SIZE  = 8,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 clear_in,
   input  logic                 disp_valid,
   input  logic [ROB_WIDTH-1:0] disp_tag,
   input  logic [2:0]           disp_op,
   output logic                 full,
   input  logic                 agu_valid,
   input  logic [ROB_WIDTH-1:0] agu_tag,
   input  logic [31:0]          agu_addr,
   input  logic [31:0]          agu_sdata,
   input  logic                 commit_valid,
   input  logic [ROB_WIDTH-1:0] commit_tag,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic [31:0]          mem_addr,
   output logic [1:0]           mem_len,
   output logic [31:0]          mem_wdata,
   input  logic                 mem_done,
   input  logic [31:0]          mem_rdata,
   output logic                 ld_valid,
   output logic [ROB_WIDTH-1:0] ld_tag,
   output logic [31:0]          ld_data
);
   localparam logic [LSB_WIDTH:0] FULL_AT = (LSB_WIDTH+1)'(LSB_SIZE - 1);

   logic [LSB_SIZE-1:0]  valid_q, valid_d, addr_ok_q, addr_ok_d, committed_q, committed_d;
   logic [ROB_WIDTH-1:0] tag_q   [LSB_SIZE];
   logic [ROB_WIDTH-1:0] tag_d   [LSB_SIZE];
   logic [2:0]           op_q    [LSB_SIZE];
   logic [2:0]           op_d    [LSB_SIZE];
   logic [31:0]          addr_q  [LSB_SIZE];
   logic [31:0]          addr_d  [LSB_SIZE];
   logic [31:0]          sdata_q [LSB_SIZE];
   logic [31:0]          sdata_d [LSB_SIZE];

   logic [LSB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
   logic [LSB_WIDTH:0]   count_q, count_d, commit_cnt_q, commit_cnt_d;
   lsb_state_e           state_q, state_d;

   logic                 full_q, full_d, mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [31:0]          mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic [1:0]           mem_len_q, mem_len_d;
   logic                 ld_valid_q, ld_valid_d;
   logic [ROB_WIDTH-1:0] ld_tag_q, ld_tag_d;
   logic [31:0]          ld_data_q, ld_data_d;
   logic [2:0]           cur_op_q, cur_op_d;

   logic                 head_ok, enq, pop, store_pop, commit_hit;
   logic [31:0]          ext_data;

   lsb_load_ext u_load_ext (
      .op_i      (cur_op_q),
      .addr_lo_i (mem_addr_q[1:0]),
      .rdata_i   (mem_rdata),
      .data_o    (ext_data)
   );

   always_comb begin
      valid_d     = valid_q;
      addr_ok_d   = addr_ok_q;
      committed_d = committed_q;
      tag_d       = tag_q;
      op_d        = op_q;
      addr_d      = addr_q;
      sdata_d     = sdata_q;
      head_d      = head_q;
      tail_d      = tail_q;
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_len_d   = mem_len_q;
      mem_wdata_d = mem_wdata_q;
      cur_op_d    = cur_op_q;
      ld_valid_d  = 1'b0;
      ld_tag_d    = ld_tag_q;
      ld_data_d   = ld_data_q;
      pop         = 1'b0;
      store_pop   = 1'b0;
      commit_hit  = 1'b0;
      enq         = disp_valid && !full_q && !clear_in;
      head_ok     = valid_q[head_q] && addr_ok_q[head_q] &&
                    (!is_store(op_q[head_q]) || committed_q[head_q]);

      // Tag CAM over valid entries for AGU results and store commits.
      for (int i = 0; i < LSB_SIZE; i++) begin
         if (agu_valid && valid_q[i] && tag_q[i] == agu_tag) begin
            addr_ok_d[i] = 1'b1;
            addr_d[i]    = agu_addr;
            sdata_d[i]   = agu_sdata;
         end
         if (commit_valid && valid_q[i] && !committed_q[i] && is_store(op_q[i]) &&
             tag_q[i] == commit_tag) begin
            committed_d[i] = 1'b1;
            commit_hit     = 1'b1;
         end
      end

      if (enq) begin
         valid_d[tail_q]     = 1'b1;
         addr_ok_d[tail_q]   = 1'b0;
         committed_d[tail_q] = 1'b0;
         tag_d[tail_q]       = disp_tag;
         op_d[tail_q]        = disp_op;
         tail_d              = tail_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            // No new issue during a flush: the head may be about to vanish.
            if (head_ok && !clear_in) begin
               mem_req_d   = 1'b1;
               mem_we_d    = is_store(op_q[head_q]);
               mem_addr_d  = addr_q[head_q];
               mem_len_d   = op_len(op_q[head_q]);
               mem_wdata_d = sdata_q[head_q];
               cur_op_d    = op_q[head_q];
               state_d     = is_store(op_q[head_q]) ? ST_STORE : ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (mem_done) begin
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
               // A flush landing on the completion cycle discards the result.
               if (!clear_in) begin
                  pop        = 1'b1;
                  ld_valid_d = 1'b1;
                  ld_tag_d   = tag_q[head_q];
                  ld_data_d  = ext_data;
               end
            end else if (clear_in) begin
               state_d = ST_DRAIN;
            end
         end
         ST_STORE: begin
            if (mem_done) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               pop       = 1'b1;
               store_pop = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_done) begin
               mem_req_d = 1'b0;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (pop) begin
         valid_d[head_q]     = 1'b0;
         addr_ok_d[head_q]   = 1'b0;
         committed_d[head_q] = 1'b0;
         head_d              = head_q + 1'b1;
      end

      commit_cnt_d = commit_cnt_q + (LSB_WIDTH+1)'(commit_hit) - (LSB_WIDTH+1)'(store_pop);
      count_d      = count_q + (LSB_WIDTH+1)'(enq) - (LSB_WIDTH+1)'(pop);

      // Committed stores sit contiguously at the head, so keeping only the
      // committed entries and rebuilding tail from head is sufficient.
      if (clear_in) begin
         valid_d   = valid_d & committed_d;
         addr_ok_d = addr_ok_d & committed_d;
         tail_d    = head_d + commit_cnt_d[LSB_WIDTH-1:0];
         count_d   = commit_cnt_d;
      end

      full_d = (count_d >= FULL_AT);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_q      <= '0;
         addr_ok_q    <= '0;
         committed_q  <= '0;
         for (int i = 0; i < LSB_SIZE; i++) begin
            tag_q[i]   <= '0;
            op_q[i]    <= '0;
            addr_q[i]  <= '0;
            sdata_q[i] <= '0;
         end
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         commit_cnt_q <= '0;
         state_q      <= ST_IDLE;
         full_q       <= 1'b0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_len_q    <= '0;
         mem_wdata_q  <= '0;
         cur_op_q     <= '0;
         ld_valid_q   <= 1'b0;
         ld_tag_q     <= '0;
         ld_data_q    <= '0;
      end else if (rdy_in) begin
         valid_q      <= valid_d;
         addr_ok_q    <= addr_ok_d;
         committed_q  <= committed_d;
         tag_q        <= tag_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         sdata_q      <= sdata_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         commit_cnt_q <= commit_cnt_d;
         state_q      <= state_d;
         full_q       <= full_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_len_q    <= mem_len_d;
         mem_wdata_q  <= mem_wdata_d;
         cur_op_q     <= cur_op_d;
         ld_valid_q   <= ld_valid_d;
         ld_tag_q     <= ld_tag_d;
         ld_data_q    <= ld_data_d;
      end
   end

   assign full      = full_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_len   = mem_len_q;
   assign mem_wdata = mem_wdata_q;
   assign ld_valid  = ld_valid_q;
   assign ld_tag    = ld_tag_q;
   assign ld_data   = ld_data_q;

endmodule
